// File: rtl/bus_endpoint_fifo.sv
// Device-side bus endpoint: a TX queue drained by the bus through pndng/D_pop/pop,
// and an address-filtered RX queue filled by the bus through push/D_push.
module bus_endpoint_fifo #(
  parameter int         pckg_sz   = 16,
  parameter int         depth     = 8,
  parameter logic [7:0] ID        = 8'h00,
  parameter logic [7:0] broadcast = 8'hFF
) (
  input  logic                         clk,
  input  logic                         reset,
  output logic                         pndng,
  output logic [pckg_sz-1:0]           D_pop,
  input  logic                         pop,
  input  logic                         push,
  input  logic [pckg_sz-1:0]           D_push,
  input  logic                         tx_wr,
  input  logic [pckg_sz-1:0]           tx_data,
  output logic                         tx_full,
  input  logic                         rx_rd,
  output logic [pckg_sz-1:0]           rx_data,
  output logic                         rx_valid,
  output logic [$clog2(depth+1)-1:0]   tx_count,
  output logic [$clog2(depth+1)-1:0]   rx_count,
  output logic [2:0]                   err
);

  localparam int AW = $clog2(depth);
  localparam int CW = $clog2(depth+1);

  logic [pckg_sz-1:0] tx_mem_q [depth];
  logic [pckg_sz-1:0] tx_mem_d [depth];
  logic [pckg_sz-1:0] rx_mem_q [depth];
  logic [pckg_sz-1:0] rx_mem_d [depth];
  logic [AW-1:0]      tx_wr_ptr_q, tx_wr_ptr_d, tx_rd_ptr_q, tx_rd_ptr_d;
  logic [AW-1:0]      rx_wr_ptr_q, rx_wr_ptr_d, rx_rd_ptr_q, rx_rd_ptr_d;
  logic [CW-1:0]      tx_count_q, tx_count_d, rx_count_q, rx_count_d;
  logic [2:0]         err_q, err_d;

  logic tx_empty_s, tx_full_s, rx_empty_s, rx_full_s;
  logic tx_do_wr_s, tx_do_pop_s, rx_match_s, rx_do_wr_s, rx_do_rd_s;
  logic [7:0] rx_dest_s;

  assign tx_empty_s  = (tx_count_q == {CW{1'b0}});
  assign tx_full_s   = (tx_count_q == CW'(depth));
  assign rx_empty_s  = (rx_count_q == {CW{1'b0}});
  assign rx_full_s   = (rx_count_q == CW'(depth));
  assign rx_dest_s   = D_push[pckg_sz-1 -: 8];

  // A full queue still accepts a write when the same cycle frees a slot.
  assign tx_do_pop_s = pop & ~tx_empty_s;
  assign tx_do_wr_s  = tx_wr & (~tx_full_s | tx_do_pop_s);
  assign rx_match_s  = push & ((rx_dest_s == ID) | (rx_dest_s == broadcast));
  assign rx_do_rd_s  = rx_rd & ~rx_empty_s;
  assign rx_do_wr_s  = rx_match_s & (~rx_full_s | rx_do_rd_s);

  always_comb begin
    tx_mem_d    = tx_mem_q;
    rx_mem_d    = rx_mem_q;
    tx_wr_ptr_d = tx_wr_ptr_q;
    tx_rd_ptr_d = tx_rd_ptr_q;
    rx_wr_ptr_d = rx_wr_ptr_q;
    rx_rd_ptr_d = rx_rd_ptr_q;
    tx_count_d  = tx_count_q;
    rx_count_d  = rx_count_q;

    if (tx_do_wr_s) begin
      tx_mem_d[tx_wr_ptr_q] = tx_data;
      tx_wr_ptr_d = tx_wr_ptr_q + AW'(1);
    end else begin
      tx_wr_ptr_d = tx_wr_ptr_q;
    end
    if (tx_do_pop_s) begin
      tx_rd_ptr_d = tx_rd_ptr_q + AW'(1);
    end else begin
      tx_rd_ptr_d = tx_rd_ptr_q;
    end
    if (tx_do_wr_s && !tx_do_pop_s) begin
      tx_count_d = tx_count_q + CW'(1);
    end else if (!tx_do_wr_s && tx_do_pop_s) begin
      tx_count_d = tx_count_q - CW'(1);
    end else begin
      tx_count_d = tx_count_q;
    end

    if (rx_do_wr_s) begin
      rx_mem_d[rx_wr_ptr_q] = D_push;
      rx_wr_ptr_d = rx_wr_ptr_q + AW'(1);
    end else begin
      rx_wr_ptr_d = rx_wr_ptr_q;
    end
    if (rx_do_rd_s) begin
      rx_rd_ptr_d = rx_rd_ptr_q + AW'(1);
    end else begin
      rx_rd_ptr_d = rx_rd_ptr_q;
    end
    if (rx_do_wr_s && !rx_do_rd_s) begin
      rx_count_d = rx_count_q + CW'(1);
    end else if (!rx_do_wr_s && rx_do_rd_s) begin
      rx_count_d = rx_count_q - CW'(1);
    end else begin
      rx_count_d = rx_count_q;
    end

    // Sticky flags: {rx overflow, pop while empty, tx overflow}.
    err_d = err_q | {rx_match_s & rx_full_s & ~rx_do_rd_s,
                     pop & tx_empty_s,
                     tx_wr & tx_full_s & ~tx_do_pop_s};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      tx_mem_q    <= '{default: '0};
      rx_mem_q    <= '{default: '0};
      tx_wr_ptr_q <= {AW{1'b0}};
      tx_rd_ptr_q <= {AW{1'b0}};
      rx_wr_ptr_q <= {AW{1'b0}};
      rx_rd_ptr_q <= {AW{1'b0}};
      tx_count_q  <= {CW{1'b0}};
      rx_count_q  <= {CW{1'b0}};
      err_q       <= 3'b000;
    end else begin
      tx_mem_q    <= tx_mem_d;
      rx_mem_q    <= rx_mem_d;
      tx_wr_ptr_q <= tx_wr_ptr_d;
      tx_rd_ptr_q <= tx_rd_ptr_d;
      rx_wr_ptr_q <= rx_wr_ptr_d;
      rx_rd_ptr_q <= rx_rd_ptr_d;
      tx_count_q  <= tx_count_d;
      rx_count_q  <= rx_count_d;
      err_q       <= err_d;
    end
  end

  // Heads read as zero while their queue is empty so no stale data leaks out.
  assign pndng    = ~tx_empty_s;
  assign tx_full  = tx_full_s;
  assign D_pop    = tx_empty_s ? {pckg_sz{1'b0}} : tx_mem_q[tx_rd_ptr_q];
  assign rx_valid = ~rx_empty_s;
  assign rx_data  = rx_empty_s ? {pckg_sz{1'b0}} : rx_mem_q[rx_rd_ptr_q];
  assign tx_count = tx_count_q;
  assign rx_count = rx_count_q;
  assign err      = err_q;

endmodule
